pll_lock_supervisor: RTL and testbench

//  Power-up/relock sequencer for the clk_pll_0 PLL, running on the PLL reference clock clkin1.
//  - Drives the PLL pll_pwd/pll_rst pins.
//  - Synchronises the asynchronous PLL lock output.
//  - Qualifies lock over a stability window, then releases sys_rst to the clkout0 logic.
//  - On lock loss or lock timeout it re-resets the PLL; after MAX_RETRIES consecutive timeouts it parks in FAIL.

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 143 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and elaboration helpers for the PLL lock supervisor.
// Codes 6 and 7 are never assigned and fall back to PWD in the FSM.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PWD  = 3'd0,
        PRST = 3'd1,
        WAIT = 3'd2,
        STAB = 3'd3,
        RUN  = 3'd4,
        FAIL = 3'd5
    } pll_state_e;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock into the clkin1 domain.
module pll_lock_sync
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clkin1,
    input  logic rst,
    input  logic lock_i,
    output logic lock_s_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clkin1) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
        end
    end

    assign lock_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Power-up / relock sequencer for clk_pll_0: drives PLL pwd/rst, qualifies lock,
// and holds downstream sys_rst until lock has been stable for a full window.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int  SYNC_STAGES    = 3,
    parameter int  PWD_CYCLES     = 4,
    parameter int  PLL_RST_CYCLES = 4,
    parameter int  LOCK_TIMEOUT   = 2500,
    parameter int  STABLE_CYCLES  = 64,
    parameter int  MAX_RETRIES    = 3,
    parameter int  CNT_W          = 8,
    localparam int RW             = clog2(MAX_RETRIES + 1)
) (
    input  logic             clkin1,
    input  logic             rst,
    input  logic             lock,
    input  logic             soft_rst_req,
    output logic             pll_pwd,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             lock_ok,
    output logic             lock_fail,
    output logic [RW-1:0]    retry_cnt,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state
);

    localparam int MAX_A = (PWD_CYCLES > PLL_RST_CYCLES) ? PWD_CYCLES : PLL_RST_CYCLES;
    localparam int MAX_B = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int TW    = clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;

    // Reload values: the timer expires on the cycle it reads zero.
    localparam logic [TW-1:0] T_PWD  = TW'(PWD_CYCLES - 1);
    localparam logic [TW-1:0] T_PRST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] T_WAIT = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_STAB = TW'(STABLE_CYCLES - 1);

    pll_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] loss_q,  loss_d;
    logic [RW-1:0]    retry_inc;
    logic             timer_zero;
    logic             lock_s;

    pll_lock_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clkin1  (clkin1),
        .rst     (rst),
        .lock_i  (lock),
        .lock_s_o(lock_s)
    );

    assign timer_zero = (timer_q == '0);
    assign retry_inc  = retry_q + RW'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_zero ? timer_q : timer_q - TW'(1);
        retry_d = retry_q;
        loss_d  = loss_q;
        // A soft request overrides everything but FAIL, including a coincident lock loss.
        if (soft_rst_req && state_q != FAIL) begin
            state_d = PRST;
            timer_d = T_PRST;
            retry_d = '0;
        end else begin
            case (state_q)
                PWD: begin
                    if (timer_zero) begin
                        state_d = PRST;
                        timer_d = T_PRST;
                    end
                end
                PRST: begin
                    if (timer_zero) begin
                        state_d = WAIT;
                        timer_d = T_WAIT;
                    end
                end
                WAIT: begin
                    if (lock_s) begin
                        state_d = STAB;
                        timer_d = T_STAB;
                    end else if (timer_zero) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RW'(MAX_RETRIES)) ? FAIL : PRST;
                        timer_d = T_PRST;
                    end
                end
                STAB: begin
                    if (!lock_s) begin
                        state_d = WAIT;
                        timer_d = T_WAIT;
                    end else if (timer_zero) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PRST;
                        timer_d = T_PRST;
                        if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
                    end
                end
                FAIL: begin
                    timer_d = timer_q;
                end
                default: begin
                    state_d = PWD;
                    timer_d = T_PWD;
                end
            endcase
        end
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q <= PWD;
            timer_q <= T_PWD;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    assign pll_pwd   = (state_q == PWD) || (state_q == FAIL);
    assign pll_rst   = (state_q == PWD) || (state_q == PRST) || (state_q == FAIL);
    assign sys_rst   = (state_q != RUN);
    assign lock_ok   = (state_q == RUN);
    assign lock_fail = (state_q == FAIL);
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bench for pll_lock_supervisor against a cycle-age reference model.
module tb_pll_lock_supervisor;

    localparam int SYNC  = 3;
    localparam int PWDC  = 4;
    localparam int PRSTC = 4;
    localparam int LT    = 100;
    localparam int STB   = 16;
    localparam int MAXR  = 2;
    localparam int CW    = 8;
    localparam int RW    = 2;

    localparam int S_PWD = 0, S_PRST = 1, S_WAIT = 2, S_STAB = 3, S_RUN = 4, S_FAIL = 5;

    logic          clkin1 = 1'b0;
    logic          rst, lock, soft_rst_req;
    logic          pll_pwd, pll_rst, sys_rst, lock_ok, lock_fail;
    logic [RW-1:0] retry_cnt;
    logic [CW-1:0] loss_cnt;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int m_state, m_age, m_retry, m_loss;
    bit lock_hist[$];

    pll_lock_supervisor #(
        .SYNC_STAGES(SYNC), .PWD_CYCLES(PWDC), .PLL_RST_CYCLES(PRSTC),
        .LOCK_TIMEOUT(LT), .STABLE_CYCLES(STB), .MAX_RETRIES(MAXR), .CNT_W(CW)
    ) dut (
        .clkin1(clkin1), .rst(rst), .lock(lock), .soft_rst_req(soft_rst_req),
        .pll_pwd(pll_pwd), .pll_rst(pll_rst), .sys_rst(sys_rst), .lock_ok(lock_ok),
        .lock_fail(lock_fail), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
    );

    always #5 clkin1 = ~clkin1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model tracks how many cycles have elapsed in the current state and the raw lock history.
    task automatic model_step();
        int  nxt;
        bit  entered;
        bit  ls;
        if (rst) begin
            m_state = S_PWD; m_age = 0; m_retry = 0; m_loss = 0;
            lock_hist = {};
            for (int i = 0; i < SYNC; i++) lock_hist.push_front(1'b0);
            return;
        end
        ls = lock_hist[SYNC-1];
        nxt = m_state;
        entered = 1'b0;
        if (soft_rst_req && m_state != S_FAIL) begin
            nxt = S_PRST; entered = 1'b1; m_retry = 0;
        end else begin
            case (m_state)
                S_PWD:  if (m_age + 1 >= PWDC)  begin nxt = S_PRST; entered = 1'b1; end
                S_PRST: if (m_age + 1 >= PRSTC) begin nxt = S_WAIT; entered = 1'b1; end
                S_WAIT: begin
                    if (ls) begin
                        nxt = S_STAB; entered = 1'b1;
                    end else if (m_age + 1 >= LT) begin
                        m_retry++;
                        nxt = (m_retry == MAXR) ? S_FAIL : S_PRST;
                        entered = 1'b1;
                    end
                end
                S_STAB: begin
                    if (!ls) begin
                        nxt = S_WAIT; entered = 1'b1;
                    end else if (m_age + 1 >= STB) begin
                        nxt = S_RUN; entered = 1'b1; m_retry = 0;
                    end
                end
                S_RUN: begin
                    if (!ls) begin
                        nxt = S_PRST; entered = 1'b1;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: ;
            endcase
        end
        m_state = nxt;
        m_age   = entered ? 0 : m_age + 1;
        lock_hist.push_front(lock);
        void'(lock_hist.pop_back());
    endtask

    task automatic cmp_model();
        chk("m_state",     32'(state),     32'(m_state));
        chk("m_pll_pwd",   32'(pll_pwd),   32'(m_state == S_PWD || m_state == S_FAIL));
        chk("m_pll_rst",   32'(pll_rst),   32'(m_state == S_PWD || m_state == S_PRST || m_state == S_FAIL));
        chk("m_sys_rst",   32'(sys_rst),   32'(m_state != S_RUN));
        chk("m_lock_ok",   32'(lock_ok),   32'(m_state == S_RUN));
        chk("m_lock_fail", 32'(lock_fail), 32'(m_state == S_FAIL));
        chk("m_retry",     32'(retry_cnt), 32'(m_retry));
        chk("m_loss",      32'(loss_cnt),  32'(m_loss));
    endtask

    task automatic tick();
        @(posedge clkin1);
        model_step();
        #1;
        cyc++;
        cmp_model();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        rst = 1'b1; lock = 1'b0; soft_rst_req = 1'b0;
        repeat (5) tick();
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_pwd", 32'(pll_pwd), 32'(1));
        chk("rst_prst", 32'(pll_rst), 32'(1));
        chk("rst_sysrst", 32'(sys_rst), 32'(1));
        chk("rst_lockok", 32'(lock_ok), 32'(0));
        chk("rst_lockfail", 32'(lock_fail), 32'(0));
        chk("rst_retry", 32'(retry_cnt), 32'(0));
        chk("rst_loss", 32'(loss_cnt), 32'(0));

        // Power-up sequence timing
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            chk("s1_pwd", 32'(pll_pwd), 32'(cyc < 4));
            chk("s1_prst", 32'(pll_rst), 32'(cyc < 8));
        end
        chk("s1_wait", 32'(state), 32'(S_WAIT));

        // First lock
        run_to(20); lock = 1'b1;
        run_to(23); chk("s2_still_wait", 32'(state), 32'(S_WAIT));
        run_to(24); chk("s2_stab", 32'(state), 32'(S_STAB));
        run_to(39); chk("s2_sysrst_hi", 32'(sys_rst), 32'(1));
        run_to(40);
        chk("s2_run", 32'(state), 32'(S_RUN));
        chk("s2_sysrst_lo", 32'(sys_rst), 32'(0));
        chk("s2_lockok", 32'(lock_ok), 32'(1));
        chk("s2_retry", 32'(retry_cnt), 32'(0));

        // Short lock loss in RUN
        run_to(50); lock = 1'b0;
        run_to(52); lock = 1'b1;
        run_to(53); chk("s3_sysrst_lo", 32'(sys_rst), 32'(0));
        run_to(54);
        chk("s3_sysrst_hi", 32'(sys_rst), 32'(1));
        chk("s3_loss", 32'(loss_cnt), 32'(1));
        chk("s3_prst", 32'(state), 32'(S_PRST));
        run_to(57); chk("s3_pllrst_hi", 32'(pll_rst), 32'(1));
        run_to(58); chk("s3_pllrst_lo", 32'(pll_rst), 32'(0));
        run_to(74); chk("s3_stab", 32'(state), 32'(S_STAB));
        run_to(75); chk("s3_relock", 32'(state), 32'(S_RUN));

        // Soft request coincident with synchronised lock loss
        run_to(80); lock = 1'b0;
        run_to(83); soft_rst_req = 1'b1;
        run_to(84); soft_rst_req = 1'b0; lock = 1'b1;
        chk("s6_prst", 32'(state), 32'(S_PRST));
        chk("s6_loss", 32'(loss_cnt), 32'(1));
        run_to(105); chk("s6_run", 32'(state), 32'(S_RUN));

        // Lock glitch during STAB, then a fresh WAIT window
        run_to(110); lock = 1'b0;
        run_to(114); chk("s5_loss", 32'(loss_cnt), 32'(2));
        run_to(120); lock = 1'b1;
        run_to(124); chk("s5_stab", 32'(state), 32'(S_STAB));
        run_to(125); lock = 1'b0;
        run_to(126); chk("s5_sysrst", 32'(sys_rst), 32'(1));
        run_to(129);
        chk("s5_wait", 32'(state), 32'(S_WAIT));
        chk("s5_retry", 32'(retry_cnt), 32'(0));
        run_to(225);
        chk("s5_fresh_timer", 32'(state), 32'(S_WAIT));
        chk("s5_retry_hold", 32'(retry_cnt), 32'(0));
        run_to(229);
        chk("s5_timeout", 32'(state), 32'(S_PRST));
        chk("s5_retry1", 32'(retry_cnt), 32'(1));

        // Mid-operation reset
        rst = 1'b1; tick();
        chk("r_state", 32'(state), 32'(S_PWD));
        chk("r_sysrst", 32'(sys_rst), 32'(1));
        chk("r_retry", 32'(retry_cnt), 32'(0));
        chk("r_loss", 32'(loss_cnt), 32'(0));
        tick();

        // Lock never arrives: two timeouts then FAIL
        rst = 1'b0; lock = 1'b0; cyc = 0;
        run_to(107);
        chk("s4_wait1", 32'(state), 32'(S_WAIT));
        chk("s4_retry0", 32'(retry_cnt), 32'(0));
        run_to(108);
        chk("s4_prst", 32'(state), 32'(S_PRST));
        chk("s4_retry1", 32'(retry_cnt), 32'(1));
        run_to(211); chk("s4_wait2", 32'(state), 32'(S_WAIT));
        run_to(212);
        chk("s4_fail", 32'(state), 32'(S_FAIL));
        chk("s4_lockfail", 32'(lock_fail), 32'(1));
        chk("s4_pwd", 32'(pll_pwd), 32'(1));
        chk("s4_retry2", 32'(retry_cnt), 32'(2));
        for (int k = 0; k < 60; k++) begin
            lock = 1'($urandom_range(0, 1));
            soft_rst_req = ($urandom_range(0, 5) == 0);
            tick();
            chk("s4_sticky", 32'(state), 32'(S_FAIL));
        end
        soft_rst_req = 1'b0;
        rst = 1'b1; tick();
        chk("s4_rst_state", 32'(state), 32'(S_PWD));
        chk("s4_rst_fail", 32'(lock_fail), 32'(0));
        chk("s4_rst_retry", 32'(retry_cnt), 32'(0));

        // Randomized lock segments, soft requests and resets
        rst = 1'b0;
        begin
            int budget = 0;
            while (budget < 3000) begin
                int len;
                bit lv;
                lv  = 1'($urandom_range(0, 1));
                len = lv ? $urandom_range(1, 60) : $urandom_range(1, 140);
                lock = lv;
                for (int k = 0; k < len; k++) begin
                    soft_rst_req = ($urandom_range(0, 79) == 0);
                    rst = ($urandom_range(0, 599) == 0);
                    tick();
                    budget++;
                end
            end
        end
        rst = 1'b0; soft_rst_req = 1'b0;

        // Loss counter saturation
        rst = 1'b1; tick(); tick();
        rst = 1'b0; lock = 1'b1;
        for (int i = 0; i < 260; i++) begin
            int n = 0;
            while (state !== 3'(S_RUN) && n < 200) begin tick(); n++; end
            chk("d_run", 32'(state), 32'(S_RUN));
            lock = 1'b0; tick(); tick(); lock = 1'b1;
            n = 0;
            while (state === 3'(S_RUN) && n < 20) begin tick(); n++; end
            chk("d_left_run", 32'(state != 3'(S_RUN)), 32'(1));
        end
        repeat (10) tick();
        chk("d_loss_sat", 32'(loss_cnt), 32'(255));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
